plane_bit_memory: RTL and testbench

PLANE_BIT_MEMORY -- requirements
Module: plane_bit_memory

---
 rtl/plane_mem_pkg.sv | 30 +++
 rtl/plane_index_map.sv | 36 +++
 rtl/plane_bit_memory.sv | 154 +++++++++++++++
 tb/tb_plane_bit_memory.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plane_mem_pkg.sv
// ============================================================================
//  Module      : plane_mem_pkg
//  Description : Shared types and default geometry for the plane bit memory.
//                Holds the controller state encoding, the default plane
//                geometry and a small width helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package plane_mem_pkg;

    localparam int DEF_ROWS   = 5;
    localparam int DEF_COLS   = 5;
    localparam int DEF_PLANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    // Plane-select width: a single plane still needs a 1-bit select port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/plane_index_map.sv
// ============================================================================
//  Module      : plane_index_map
//  Description : Maps a logical bit index onto the physical bit position of a
//                plane (reversed: physical = W-1-index) and flags whether the
//                index/plane pair addresses real storage.
//  Ports       : index    - logical bit index
//                plane    - plane select
//                phys     - physical bit position (0 when out of range)
//                in_range - index < W and plane < PLANES
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module plane_index_map #(
    parameter int W      = 25,
    parameter int IW     = 5,
    parameter int PLANES = 4,
    parameter int PW     = 2
) (
    input  logic [IW-1:0] index,
    input  logic [PW-1:0] plane,
    output logic [IW-1:0] phys,
    output logic          in_range
);

    localparam logic [IW-1:0] c_top_bit = IW'(W - 1);

    assign in_range = (32'(index) < 32'(W)) && (32'(plane) < 32'(PLANES));

    // Park the physical position at 0 when out of range so downstream
    // indexing never goes past the end of a plane.
    assign phys = in_range ? (c_top_bit - index) : '0;

endmodule

`default_nettype wire

// File: rtl/plane_bit_memory.sv
// ============================================================================
//  Module      : plane_bit_memory
//  Description : Stores PLANES bit-planes of ROWS*COLS bits. Planes are bulk
//                loaded and dumped through valid/ready streams; in RUN single
//                bits are read (latency 1) and written by logical index.
//  Ports       : clk, rst            - clock, async active-high reset
//                start_load/start_dump - enter LOAD / DUMP
//                ld_valid/ld_ready/ld_data - plane load stream
//                rd_en/wr_en/plane/index/wr_bit/inj_bit - bit access
//                rd_bit/rd_valid/err - read result and out-of-range pulse
//                dp_valid/dp_ready/dp_data/dp_last - plane dump stream
//                busy                - high in LOAD and DUMP
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module plane_bit_memory
    import plane_mem_pkg::*;
#(
    parameter  int ROWS   = DEF_ROWS,
    parameter  int COLS   = DEF_COLS,
    parameter  int PLANES = DEF_PLANES,
    localparam int W      = ROWS * COLS,
    localparam int IW     = $clog2(W),
    localparam int PW     = clog2_min1(PLANES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_load,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [W-1:0]  ld_data,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [PW-1:0] plane,
    input  logic [IW-1:0] index,
    input  logic          wr_bit,
    input  logic          inj_bit,
    output logic          rd_bit,
    output logic          rd_valid,
    output logic          err,
    input  logic          start_dump,
    output logic          dp_valid,
    input  logic          dp_ready,
    output logic [W-1:0]  dp_data,
    output logic          dp_last,
    input  logic          busy_unused_guard_n = 1'b1,
    output logic          busy
);

    localparam logic [PW:0] c_last_cnt = (PW + 1)'(PLANES - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [PW:0]   r_cnt;
    logic [W-1:0]  r_planes [PLANES];

    logic [PW-1:0] w_cnt_sel;
    logic [IW-1:0] w_phys;
    logic          w_in_range;
    logic          w_run;
    logic          w_ld_beat;
    logic          w_dp_beat;

    plane_index_map #(
        .W      (W),
        .IW     (IW),
        .PLANES (PLANES),
        .PW     (PW)
    ) u_index_map (
        .index    (index),
        .plane    (plane),
        .phys     (w_phys),
        .in_range (w_in_range)
    );

    // Counter only ever reaches PLANES-1 before the state is left, so the
    // low PW bits address the plane array directly.
    assign w_cnt_sel = r_cnt[PW-1:0];
    assign w_run     = (r_state == ST_RUN);

    assign ld_ready  = (r_state == ST_LOAD);
    assign w_ld_beat = ld_ready & ld_valid;

    assign dp_valid  = (r_state == ST_DUMP);
    assign dp_last   = dp_valid && (r_cnt == c_last_cnt);
    assign dp_data   = dp_valid ? r_planes[w_cnt_sel] : '0;
    assign w_dp_beat = dp_valid & dp_ready;

    assign busy      = ld_ready | dp_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start_load) w_state_next = ST_LOAD;
            ST_LOAD: if (w_ld_beat && (r_cnt == c_last_cnt)) w_state_next = ST_RUN;
            ST_RUN: begin
                if (start_load)      w_state_next = ST_LOAD;
                else if (start_dump) w_state_next = ST_DUMP;
            end
            ST_DUMP: if (w_dp_beat && dp_last) w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Beat counter restarts on every state change so each LOAD/DUMP begins
    // at plane 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (w_ld_beat || w_dp_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Read path samples storage before this edge's write lands, giving
    // read-before-write on a same-bit collision. Index 0 returns inj_bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bit   <= 1'b0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= w_run & rd_en;
            err      <= w_run & (rd_en | wr_en) & ~w_in_range;
            if (w_run && rd_en) begin
                if (!w_in_range)       rd_bit <= 1'b0;
                else if (index == '0)  rd_bit <= inj_bit;
                else                   rd_bit <= r_planes[plane][w_phys];
            end
        end
    end

    // Plane storage is deliberately not reset; it is defined by LOAD.
    always_ff @(posedge clk) begin
        if (w_ld_beat) begin
            r_planes[w_cnt_sel] <= ld_data;
        end else if (w_run && wr_en && w_in_range) begin
            r_planes[plane][w_phys] <= wr_bit;
        end
    end

    logic w_unused;
    assign w_unused = busy_unused_guard_n;

endmodule

`default_nettype wire

// File: tb/tb_plane_bit_memory.sv
// ============================================================================
//  Module      : tb_plane_bit_memory
//  Description : Self-checking bench for plane_bit_memory: load, table of
//                bit read/write vectors, stalled dump, and reset during dump.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_plane_bit_memory;

    localparam int W      = 25;
    localparam int IW     = 5;
    localparam int PW     = 2;
    localparam int PLANES = 4;
    localparam int NVEC   = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [W-1:0]  ld_data = '0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [PW-1:0] plane = '0;
    logic [IW-1:0] index = '0;
    logic          wr_bit = 1'b0;
    logic          inj_bit = 1'b0;
    logic          rd_bit;
    logic          rd_valid;
    logic          err;
    logic          start_dump = 1'b0;
    logic          dp_valid;
    logic          dp_ready = 1'b0;
    logic [W-1:0]  dp_data;
    logic          dp_last;
    logic          busy;

    plane_bit_memory dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_load          (start_load),
        .ld_valid            (ld_valid),
        .ld_ready            (ld_ready),
        .ld_data             (ld_data),
        .rd_en               (rd_en),
        .wr_en               (wr_en),
        .plane               (plane),
        .index               (index),
        .wr_bit              (wr_bit),
        .inj_bit             (inj_bit),
        .rd_bit              (rd_bit),
        .rd_valid            (rd_valid),
        .err                 (err),
        .start_dump          (start_dump),
        .dp_valid            (dp_valid),
        .dp_ready            (dp_ready),
        .dp_data             (dp_data),
        .dp_last             (dp_last),
        .busy_unused_guard_n (1'b1),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [PW-1:0] pl;
        logic [IW-1:0] idx;
        logic          wb;
        logic          inj;
        logic          e_valid;
        logic          e_bit;
        logic          e_err;
    } vec_t;

    vec_t         vecs [NVEC];
    logic [W-1:0] load_data [PLANES];
    logic [W-1:0] dump_exp  [PLANES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_zero_word();
        return {24'd0, ld_ready, rd_bit, rd_valid, err, dp_valid, dp_last, busy, |dp_data};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        load_data[0] = 25'h1000001;
        load_data[1] = 25'h0AAAAAA;
        load_data[2] = 25'h1555555;
        load_data[3] = 25'h0000000;

        // Planes after the vector table: p0 logical 0 (phys 24) cleared,
        // p1 logical 2 (phys 22) set, p3 logical 5 (phys 19) set.
        dump_exp[0] = 25'h0000001;
        dump_exp[1] = 25'h0EAAAAA;
        dump_exp[2] = 25'h1555555;
        dump_exp[3] = 25'h0080000;

        //              rd    wr    pl    idx    wb    inj   valid bit   err
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 5'd24, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 5'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 5'd1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd3, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 5'd25, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'd2, 5'd28, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 2'd1, 5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 2'd1, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 2'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 2'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 2'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 2'd2, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        check("reset_outputs", outs_zero_word(), 32'd0);
        rst = 1'b0;
        tick();

        // Bit access outside RUN is ignored
        rd_en = 1'b1; wr_en = 1'b1; index = 5'd25;
        tick();
        rd_en = 1'b0; wr_en = 1'b0; index = '0;
        check("idle_access_ignored", {30'd0, rd_valid, err}, 32'd0);

        // Load four planes, with one stall cycle before the third beat
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        check("load_entry", {30'd0, ld_ready, busy}, 32'd3);
        for (int k = 0; k < PLANES; k++) begin
            if (k == 2) begin
                ld_valid = 1'b0;
                tick();
                check("load_stall_ready", {31'd0, ld_ready}, 32'd1);
            end
            ld_valid = 1'b1;
            ld_data  = load_data[k];
            tick();
        end
        ld_valid = 1'b0;
        ld_data  = '0;
        check("load_done", {30'd0, ld_ready, busy}, 32'd0);

        // Vector table in RUN
        for (int i = 0; i < NVEC; i++) begin
            rd_en   = vecs[i].rd;
            wr_en   = vecs[i].wr;
            plane   = vecs[i].pl;
            index   = vecs[i].idx;
            wr_bit  = vecs[i].wb;
            inj_bit = vecs[i].inj;
            tick();
            check($sformatf("vec%0d_valid_bit_err", i),
                  {29'd0, rd_valid, (vecs[i].e_valid ? rd_bit : 1'b0), err},
                  {29'd0, vecs[i].e_valid, vecs[i].e_bit, vecs[i].e_err});
        end
        rd_en = 1'b0; wr_en = 1'b0; wr_bit = 1'b0; inj_bit = 1'b0;

        // Dump with three stalled cycles, then four accepted beats
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        check("dump_entry", {30'd0, dp_valid, busy}, 32'd3);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("dump_stall%0d_data", s), 32'(dp_data), 32'(dump_exp[0]));
            tick();
        end
        dp_ready = 1'b1;
        for (int k = 0; k < PLANES; k++) begin
            check($sformatf("dump_beat%0d_data", k), 32'(dp_data), 32'(dump_exp[k]));
            check($sformatf("dump_beat%0d_last", k), {31'd0, dp_last}, {31'd0, k == PLANES - 1});
            tick();
        end
        dp_ready = 1'b0;
        check("dump_done", {30'd0, dp_valid, busy}, 32'd0);

        // Contents persist after a dump
        rd_en = 1'b1; plane = 2'd3; index = 5'd5;
        tick();
        rd_en = 1'b0;
        check("post_dump_read", {30'd0, rd_valid, rd_bit}, 32'd3);

        // Reset asserted while the second dump beat is presented
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        dp_ready = 1'b1;
        tick();
        check("rstdump_beat2_data", 32'(dp_data), 32'(dump_exp[1]));
        #2 rst = 1'b1;
        #1;
        check("rstdump_immediate", outs_zero_word(), 32'd0);
        tick();
        check("rstdump_next_edge", outs_zero_word(), 32'd0);
        dp_ready = 1'b0;
        #3 rst = 1'b0;
        tick();

        // Back in IDLE: dump request and bit reads are ignored
        start_dump = 1'b1; rd_en = 1'b1; index = 5'd25;
        tick();
        start_dump = 1'b0; rd_en = 1'b0;
        check("post_rst_idle", {29'd0, busy, rd_valid, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
